// File: rtl/lsu_byte_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_byte_master
//  Purpose  : Load/store unit for a byte-wide, big-endian data memory port.
//             Splits one 32-bit load/store into byte-serial memory accesses,
//             reassembles load bytes with sign/zero extension, and returns
//             the result through a valid/ready response handshake.
//  Option   : LSU_ALIGN_CHK_EN - reject misaligned word/half requests with
//             rsp_err=1 and no memory access.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_byte_master #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_ld,
  input  logic [1:0]        req_st,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  // Load type encodings (DMRE_*); unlisted values mean "no load".
  localparam logic [2:0] c_dmre_lw  = 3'd1;
  localparam logic [2:0] c_dmre_lh  = 3'd2;
  localparam logic [2:0] c_dmre_lhu = 3'd3;
  localparam logic [2:0] c_dmre_lb  = 3'd4;
  localparam logic [2:0] c_dmre_lbu = 3'd5;
  // Store type encodings (DMWR_*); unlisted values mean "no store".
  localparam logic [1:0] c_dmwr_sw  = 2'd1;
  localparam logic [1:0] c_dmwr_sh  = 2'd2;
  localparam logic [1:0] c_dmwr_sb  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;       // index of the next byte to issue
  logic [2:0]          n_q, n_d;           // bytes in this access (1/2/4)
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2:0]          ld_q, ld_d;
  logic                is_ld_q, is_ld_d;
  logic [31:0]         sdata_q, sdata_d;   // store bytes, next one in [31:24]
  logic [23:0]         acc_q, acc_d;       // earlier load bytes; last byte comes from mem_rdata
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                w_is_ld;
  logic                w_is_st;
  logic [2:0]          w_n;
  logic [31:0]         w_sdata;
  logic                w_misalign;
  logic [31:0]         w_ld_word;

  // Sign/zero extension of the assembled big-endian load bytes.
  function automatic logic [31:0] f_extend(input logic [2:0] ld, input logic [31:0] w);
    case (ld)
      c_dmre_lh:  f_extend = {{16{w[15]}}, w[15:0]};
      c_dmre_lhu: f_extend = {16'h0000, w[15:0]};
      c_dmre_lb:  f_extend = {{24{w[7]}}, w[7:0]};
      c_dmre_lbu: f_extend = {24'h000000, w[7:0]};
      default:    f_extend = w;
    endcase
  endfunction

  // Request decode: load wins over store, byte count, store data alignment.
  always_comb begin
    w_is_ld = (req_ld == c_dmre_lw) || (req_ld == c_dmre_lh) || (req_ld == c_dmre_lhu) ||
              (req_ld == c_dmre_lb) || (req_ld == c_dmre_lbu);
    w_is_st = !w_is_ld &&
              ((req_st == c_dmwr_sw) || (req_st == c_dmwr_sh) || (req_st == c_dmwr_sb));
    if (w_is_ld) begin
      case (req_ld)
        c_dmre_lw:              w_n = 3'd4;
        c_dmre_lh, c_dmre_lhu:  w_n = 3'd2;
        default:                w_n = 3'd1;
      endcase
    end else begin
      case (req_st)
        c_dmwr_sw: w_n = 3'd4;
        c_dmwr_sh: w_n = 3'd2;
        default:   w_n = 3'd1;
      endcase
    end
    // Left-justify the store bytes so the first byte sent is always [31:24].
    case (w_n)
      3'd4:    w_sdata = req_wdata;
      3'd2:    w_sdata = {req_wdata[15:0], 16'h0000};
      default: w_sdata = {req_wdata[7:0], 24'h000000};
    endcase
`ifdef LSU_ALIGN_CHK_EN
    w_misalign = ((w_n == 3'd4) && (req_addr[1:0] != 2'b00)) ||
                 ((w_n == 3'd2) && req_addr[0]);
`else
    w_misalign = 1'b0;
`endif
    w_ld_word = {acc_q, mem_rdata};
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    ld_d        = ld_q;
    is_ld_d     = is_ld_q;
    sdata_d     = sdata_q;
    acc_d       = rd_pend_q ? {acc_q[15:0], mem_rdata} : acc_q;
    rd_pend_d   = mem_re_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d     = req_addr;
          ld_d       = req_ld;
          is_ld_d    = w_is_ld;
          n_d        = w_n;
          acc_d      = 24'h000000;
          rsp_data_d = 32'h0000_0000;
          rsp_err_d  = 1'b0;
          if (!w_is_ld && !w_is_st) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
          end else if (w_misalign) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            // Byte 0 is issued in the cycle right after acceptance.
            state_d    = XFER;
            cnt_d      = 3'd1;
            mem_addr_d = req_addr;
            mem_re_d   = w_is_ld;
            mem_we_d   = w_is_st;
            if (w_is_st) begin
              mem_wdata_d = w_sdata[31:24];
              sdata_d     = {w_sdata[23:0], 8'h00};
            end
          end
        end
      end
      XFER: begin
        if (cnt_q == n_q) begin
          // The last byte is on the bus this cycle.
          cnt_d = 3'd0;
          if (is_ld_q) begin
            state_d = DRAIN;
          end else begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'h0000_0000;
          end
        end else begin
          mem_addr_d = base_q + ADDR_W'(cnt_q);
          mem_re_d   = is_ld_q;
          mem_we_d   = !is_ld_q;
          if (!is_ld_q) begin
            mem_wdata_d = sdata_q[31:24];
            sdata_d     = {sdata_q[23:0], 8'h00};
          end
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRAIN: begin
        // Final read byte arrives now; build the extended result directly.
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = f_extend(ld_q, w_ld_word);
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 32'h0000_0000;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      ld_q        <= 3'd0;
      is_ld_q     <= 1'b0;
      sdata_q     <= 32'h0000_0000;
      acc_q       <= 24'h000000;
      rd_pend_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      ld_q        <= ld_d;
      is_ld_q     <= is_ld_d;
      sdata_q     <= sdata_d;
      acc_q       <= acc_d;
      rd_pend_q   <= rd_pend_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_byte_master
//  Purpose  : Directed self-checking bench for lsu_byte_master with a
//             byte-wide registered-read memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_byte_master;

  localparam int ADDR_W = 8;
  localparam logic [2:0] c_lw = 3'd1, c_lh = 3'd2, c_lhu = 3'd3, c_lb = 3'd4, c_lbu = 3'd5;
  localparam logic [1:0] c_sw = 2'd1, c_sh = 2'd2, c_sb = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_ld;
  logic [1:0]        req_st;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  // Strobe logs of the most recent request.
  logic [7:0] re_log  [0:7];
  logic [7:0] wa_log  [0:7];
  logic [7:0] wd_log  [0:7];
  int         re_n, we_n, both_hi;

  lsu_byte_master #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ld    (req_ld),
    .req_st    (req_st),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory with a one-cycle registered read and a bench preload port.
  logic [7:0] mem [0:255];
  logic       pre_we;
  logic [7:0] pre_a, pre_d;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 8; i++) begin
      re_log[i] = 8'h00; wa_log[i] = 8'h00; wd_log[i] = 8'h00;
    end
    re_n = 0; we_n = 0; both_hi = 0;
  endtask

  task automatic log_strobes();
    if (mem_re && re_n < 8) begin re_log[re_n] = mem_addr; re_n++; end
    if (mem_we && we_n < 8) begin wa_log[we_n] = mem_addr; wd_log[we_n] = mem_wdata; we_n++; end
    if (mem_re && mem_we) both_hi++;
  endtask

  // Issue one request with rsp_ready high; lat = cycle of first rsp_valid (-1 on timeout).
  task automatic run_req(input logic [2:0] ld, input logic [1:0] st, input logic [7:0] addr,
                         input logic [31:0] wd, output logic [31:0] data, output logic err,
                         output int lat);
    clear_log();
    data = 32'h0; err = 1'b0; lat = -1;
    req_valid = 1'b1; req_ld = ld; req_st = st; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin req_valid = 1'b0; req_ld = 3'd0; req_st = 2'd0; end
      log_strobes();
      if (rsp_valid) begin lat = c; data = rsp_data; err = rsp_err; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready);
    else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_err, mem_re, mem_we} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, mem_re, mem_we});
    else n_pass++;
    n_total++;
    if ({rsp_data, mem_addr, mem_wdata} !== 48'h0)
      $display("FAIL reset_buses: got %h want 0", {rsp_data, mem_addr, mem_wdata});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_lw();
    logic [31:0] d; logic e; int lat;
    poke(8'h10, 8'h12); poke(8'h11, 8'h34); poke(8'h12, 8'h56); poke(8'h13, 8'h78);
    run_req(c_lw, 2'd0, 8'h10, 32'h0, d, e, lat);
    n_total++;
    if (lat != 6 || d !== 32'h12345678 || e !== 1'b0)
      $display("FAIL lw: got lat=%0d data=%h err=%b want lat=6 data=12345678 err=0", lat, d, e);
    else n_pass++;
    n_total++;
    if (re_n != 4 || we_n != 0 || {re_log[0], re_log[1], re_log[2], re_log[3]} !== 32'h10111213)
      $display("FAIL lw_strobes: got re_n=%0d we_n=%0d addrs=%h want 4 0 10111213", re_n, we_n,
               {re_log[0], re_log[1], re_log[2], re_log[3]});
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL lw_after: got req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [31:0] d; logic e; int lat;
    poke(8'h20, 8'h80); poke(8'h21, 8'h01);
    run_req(c_lh, 2'd0, 8'h20, 32'h0, d, e, lat);
    n_total++;
    if (lat != 4 || d !== 32'hFFFF8001) $display("FAIL lh: got lat=%0d data=%h want 4 ffff8001", lat, d);
    else n_pass++;
    run_req(c_lhu, 2'd0, 8'h20, 32'h0, d, e, lat);
    n_total++;
    if (lat != 4 || d !== 32'h00008001) $display("FAIL lhu: got lat=%0d data=%h want 4 00008001", lat, d);
    else n_pass++;
    run_req(c_lb, 2'd0, 8'h20, 32'h0, d, e, lat);
    n_total++;
    if (lat != 3 || d !== 32'hFFFFFF80) $display("FAIL lb: got lat=%0d data=%h want 3 ffffff80", lat, d);
    else n_pass++;
    run_req(c_lbu, 2'd0, 8'h20, 32'h0, d, e, lat);
    n_total++;
    if (lat != 3 || d !== 32'h00000080) $display("FAIL lbu: got lat=%0d data=%h want 3 00000080", lat, d);
    else n_pass++;
  endtask

  task automatic test_sw_wrap();
    logic [31:0] d; logic e; int lat;
    run_req(2'd0, c_sw, 8'hFE, 32'hAABBCCDD, d, e, lat);
`ifdef LSU_ALIGN_CHK_EN
    n_total++;
    if (lat != 1 || e !== 1'b1 || d !== 32'h0 || we_n != 0)
      $display("FAIL sw_misalign: got lat=%0d err=%b data=%h we_n=%0d want 1 1 0 0", lat, e, d, we_n);
    else n_pass++;
`else
    n_total++;
    if (lat != 5 || d !== 32'h0 || e !== 1'b0)
      $display("FAIL sw_rsp: got lat=%0d data=%h err=%b want 5 0 0", lat, d, e);
    else n_pass++;
    n_total++;
    if (we_n != 4 || re_n != 0 ||
        {wa_log[0], wa_log[1], wa_log[2], wa_log[3]} !== 32'hFEFF0001 ||
        {wd_log[0], wd_log[1], wd_log[2], wd_log[3]} !== 32'hAABBCCDD)
      $display("FAIL sw_bytes: got n=%0d addrs=%h data=%h want 4 feff0001 aabbccdd", we_n,
               {wa_log[0], wa_log[1], wa_log[2], wa_log[3]}, {wd_log[0], wd_log[1], wd_log[2], wd_log[3]});
    else n_pass++;
`endif
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int lat;
    run_req(2'd0, c_sh, 8'h40, 32'h1234BEEF, d, e, lat);
    n_total++;
    if (lat != 3 || we_n != 2 || {wa_log[0], wd_log[0], wa_log[1], wd_log[1]} !== 32'h40BE41EF)
      $display("FAIL sh: got lat=%0d n=%0d bytes=%h want 3 2 40be41ef", lat, we_n,
               {wa_log[0], wd_log[0], wa_log[1], wd_log[1]});
    else n_pass++;
    run_req(c_lhu, 2'd0, 8'h40, 32'h0, d, e, lat);
    n_total++;
    if (d !== 32'h0000BEEF) $display("FAIL sh_lhu: got %h want 0000beef", d);
    else n_pass++;
    run_req(2'd0, c_sb, 8'h41, 32'h00000055, d, e, lat);
    run_req(c_lbu, 2'd0, 8'h41, 32'h0, d, e, lat);
    n_total++;
    if (d !== 32'h00000055) $display("FAIL sb_lbu: got %h want 00000055", d);
    else n_pass++;
    run_req(c_lhu, 2'd0, 8'h40, 32'h0, d, e, lat);
    n_total++;
    if (d !== 32'h0000BE55) $display("FAIL sb_keep: got %h want 0000be55", d);
    else n_pass++;
  endtask

  task automatic test_priority_noop();
    logic [31:0] d; logic e; int lat;
    run_req(c_lbu, c_sb, 8'h41, 32'h000000AA, d, e, lat);
    n_total++;
    if (d !== 32'h00000055 || we_n != 0 || re_n != 1)
      $display("FAIL ld_priority: got data=%h we_n=%0d re_n=%0d want 55 0 1", d, we_n, re_n);
    else n_pass++;
    run_req(3'd6, c_sb, 8'h42, 32'h00000077, d, e, lat);
    n_total++;
    if (lat != 2 || we_n != 1 || {wa_log[0], wd_log[0]} !== 16'h4277)
      $display("FAIL bad_ld_store: got lat=%0d we_n=%0d byte=%h want 2 1 4277", lat, we_n, {wa_log[0], wd_log[0]});
    else n_pass++;
    run_req(3'd7, 2'd0, 8'h50, 32'h12345678, d, e, lat);
    n_total++;
    if (lat != 1 || d !== 32'h0 || e !== 1'b0 || re_n + we_n != 0)
      $display("FAIL noop: got lat=%0d data=%h err=%b strobes=%0d want 1 0 0 0", lat, d, e, re_n + we_n);
    else n_pass++;
    n_total++;
    if (both_hi != 0) $display("FAIL strobe_overlap: got %0d want 0", both_hi);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat; int bad; int re_seen;
    lat = -1; bad = 0; re_seen = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_ld = c_lw; req_st = 2'd0; req_addr = 8'h10; req_wdata = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin req_valid = 1'b0; req_ld = 3'd0; end
      if (rsp_valid) begin lat = c; break; end
    end
    n_total++;
    if (lat != 6) $display("FAIL bp_latency: got %0d want 6", lat);
    else n_pass++;
    req_valid = 1'b1; req_ld = c_lbu; req_addr = 8'h20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
      if (mem_re) re_seen++;
    end
    n_total++;
    if (bad != 0 || re_seen != 0)
      $display("FAIL bp_hold: got bad_cycles=%0d reads=%0d want 0 0", bad, re_seen);
    else n_pass++;
    req_valid = 1'b0; req_ld = 3'd0; rsp_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_re !== 1'b0)
      $display("FAIL bp_release: got req_ready=%b rsp_valid=%b mem_re=%b want 1 0 0", req_ready, rsp_valid, mem_re);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; int seen;
    poke(8'h60, 8'h00); poke(8'h61, 8'h00); poke(8'h62, 8'h00); poke(8'h63, 8'h00);
    req_valid = 1'b1; req_ld = 3'd0; req_st = c_sw; req_addr = 8'h60; req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_st = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL rst_mid_strobes: got we=%b re=%b rsp_valid=%b want 0 0 0", mem_we, mem_re, rsp_valid);
    else n_pass++;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_we || !req_ready) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL rst_mid_idle: got %0d bad cycles want 0", seen);
    else n_pass++;
    run_req(c_lw, 2'd0, 8'h60, 32'h0, d, e, lat);
    n_total++;
    if (d !== 32'h11220000) $display("FAIL rst_mid_mem: got %h want 11220000", d);
    else n_pass++;
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic e; int lat;
    poke(8'h14, 8'h9A);
    run_req(c_lw, 2'd0, 8'h11, 32'h0, d, e, lat);
`ifdef LSU_ALIGN_CHK_EN
    n_total++;
    if (lat != 1 || e !== 1'b1 || d !== 32'h0 || re_n != 0)
      $display("FAIL lw_misalign: got lat=%0d err=%b data=%h re_n=%0d want 1 1 0 0", lat, e, d, re_n);
    else n_pass++;
`else
    n_total++;
    if (lat != 6 || e !== 1'b0 || d !== 32'h3456789A || re_n != 4 ||
        {re_log[0], re_log[1], re_log[2], re_log[3]} !== 32'h11121314)
      $display("FAIL lw_unaligned: got lat=%0d err=%b data=%h addrs=%h want 6 0 3456789a 11121314",
               lat, e, d, {re_log[0], re_log[1], re_log[2], re_log[3]});
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_ld = 3'd0; req_st = 2'd0; req_addr = 8'h00;
    req_wdata = 32'h0; rsp_ready = 1'b1; pre_we = 1'b0; pre_a = 8'h00; pre_d = 8'h00;
    test_reset();
    test_lw();
    test_load_ext();
    test_sw_wrap();
    test_store_load();
    test_priority_noop();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
